// File: rtl/cl_pkg.sv
// Shared types and constants for the CameraLink timing controller:
// FSM state encoding, TAPS legality helpers and the fval/lval bit mapping.
package cl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LEAD,
    ST_ACTIVE,
    ST_HBLANK,
    ST_TRAIL,
    ST_VBLANK
  } cl_state_e;

  localparam int unsigned CL_SYNC_W   = 2;
  localparam int unsigned CL_FVAL_BIT = 0;
  localparam int unsigned CL_LVAL_BIT = 1;

  function automatic logic taps_legal(input int unsigned taps);
    return (taps == 1) || (taps == 2) || (taps == 4);
  endfunction

  function automatic int unsigned taps_log2(input int unsigned taps);
    return (taps == 4) ? 2 : (taps == 2) ? 1 : 0;
  endfunction

  // Frame/line valid levels that hold for the whole time a state is occupied.
  function automatic logic [CL_SYNC_W-1:0] sync_for(input cl_state_e s);
    logic [CL_SYNC_W-1:0] v;
    v              = '0;
    v[CL_FVAL_BIT] = (s != ST_IDLE) && (s != ST_VBLANK);
    v[CL_LVAL_BIT] = (s == ST_ACTIVE);
    return v;
  endfunction

endpackage

// File: rtl/cl_down_counter.sv
// Loadable down-counter with a zero flag; times the LEAD, HBLANK and VBLANK
// intervals. Load wins over decrement and the count stops at zero.
module cl_down_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic         dec_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] cnt_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - W'(1);
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/cl_timing_ctrl.sv
// CameraLink frame/line/data valid generator pulling TAPS pixels per beat
// from an upstream FIFO, with single-frame and free-run modes.
module cl_timing_ctrl
  import cl_pkg::*;
#(
  parameter int unsigned TAPS = 2,
  parameter int unsigned CW   = 16
) (
  input  logic          pixel_clk,
  input  logic          sys_rst,
  input  logic [CW-1:0] cfg_width,
  input  logic [CW-1:0] cfg_height,
  input  logic [7:0]    cfg_hblank,
  input  logic [CW-1:0] cfg_vblank,
  input  logic          cfg_cont,
  input  logic          start,
  input  logic          stop,
  input  logic          pix_avail,
  output logic          pix_rd,
  output logic          fval,
  output logic          lval,
  output logic          dval,
  output logic [CW-1:0] line_cnt,
  output logic [CW-1:0] beat_cnt,
  output logic          busy,
  output logic          frame_done,
  output logic          cfg_err
);

  localparam int unsigned TAPS_LOG2 = taps_log2(TAPS);

  if (!taps_legal(TAPS)) begin : g_bad_taps
    $error("cl_timing_ctrl: TAPS must be 1, 2 or 4");
  end

  // Counter reload value giving max(n,1) cycles in the timed state.
  function automatic logic [CW-1:0] blank_len(input logic [CW-1:0] n);
    return (n == '0) ? '0 : n - CW'(1);
  endfunction

  cl_state_e            state_q, state_d;
  logic [CL_SYNC_W-1:0] sync_q;
  logic [CW-1:0]        line_cnt_q, line_cnt_d;
  logic [CW-1:0]        beat_cnt_q, beat_cnt_d;
  logic                 busy_q, frame_done_q;
  logic                 cfg_err_q, cfg_err_d;
  logic                 pend_q, pend_d;

  logic [CW-1:0]        beats_q, height_q, vblank_q;
  logic [7:0]           hblank_q;
  logic                 cont_q;
  logic                 latch_cfg;

  logic                 cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0]        cnt_val;
  logic                 cfg_ok, rd, last_beat, last_line;

  assign cfg_ok    = (cfg_width != '0) && (cfg_height != '0) &&
                     ((cfg_width & CW'(TAPS - 1)) == '0);
  assign rd        = (state_q == ST_ACTIVE) && pix_avail;
  assign last_beat = (beat_cnt_q == beats_q - CW'(1));
  assign last_line = (line_cnt_q >= height_q - CW'(1));
  assign cnt_dec   = (state_q == ST_LEAD) || (state_q == ST_HBLANK) || (state_q == ST_VBLANK);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_d    = state_q;
    line_cnt_d = line_cnt_q;
    beat_cnt_d = beat_cnt_q;
    pend_d     = pend_q | stop;
    cfg_err_d  = 1'b0;
    latch_cfg  = 1'b0;
    cnt_load   = 1'b0;
    cnt_val    = blank_len(CW'(hblank_q));
    case (state_q)
      ST_IDLE: begin
        pend_d = 1'b0;
        if (start) begin
          if (cfg_ok) begin
            latch_cfg  = 1'b1;
            pend_d     = stop;  // start+stop together: run exactly one frame
            state_d    = ST_LEAD;
            line_cnt_d = '0;
            beat_cnt_d = '0;
            cnt_load   = 1'b1;
            cnt_val    = blank_len(CW'(cfg_hblank));
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      ST_LEAD, ST_HBLANK: begin
        if (cnt_zero) state_d = ST_ACTIVE;
      end
      ST_ACTIVE: begin
        if (rd) begin
          if (last_beat) begin
            beat_cnt_d = '0;
            if (last_line) begin
              state_d = ST_TRAIL;
            end else begin
              state_d    = ST_HBLANK;
              line_cnt_d = line_cnt_q + CW'(1);
              cnt_load   = 1'b1;
            end
          end else begin
            beat_cnt_d = beat_cnt_q + CW'(1);
          end
        end
      end
      ST_TRAIL: begin
        state_d  = ST_VBLANK;
        cnt_load = 1'b1;
        cnt_val  = blank_len(vblank_q);
      end
      ST_VBLANK: begin
        if (cnt_zero) begin
          if (cont_q && !pend_d) begin
            state_d    = ST_LEAD;
            line_cnt_d = '0;
            cnt_load   = 1'b1;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q      <= ST_IDLE;
      sync_q       <= '0;
      line_cnt_q   <= '0;
      beat_cnt_q   <= '0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sync_q       <= sync_for(state_d);
      line_cnt_q   <= line_cnt_d;
      beat_cnt_q   <= beat_cnt_d;
      busy_q       <= (state_d != ST_IDLE);
      frame_done_q <= (state_d == ST_TRAIL);
      cfg_err_q    <= cfg_err_d;
      pend_q       <= (state_d == ST_IDLE) ? 1'b0 : pend_d;
    end
  end

  // NOTE: shadow config is always written before it is read, so it carries no reset.
  always_ff @(posedge pixel_clk) begin
    if (latch_cfg) begin
      beats_q  <= cfg_width >> TAPS_LOG2;
      height_q <= cfg_height;
      hblank_q <= cfg_hblank;
      vblank_q <= cfg_vblank;
      cont_q   <= cfg_cont;
    end
  end

  cl_down_counter #(.W(CW)) u_blank_cnt (
    .clk        (pixel_clk),
    .rst        (sys_rst),
    .load_i     (cnt_load),
    .dec_i      (cnt_dec),
    .load_val_i (cnt_val),
    .zero_o     (cnt_zero)
  );

  assign fval       = sync_q[CL_FVAL_BIT];
  assign lval       = sync_q[CL_LVAL_BIT];
  assign dval       = rd;
  assign pix_rd     = rd;
  assign line_cnt   = line_cnt_q;
  assign beat_cnt   = beat_cnt_q;
  assign busy       = busy_q;
  assign frame_done = frame_done_q;
  assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_cl_timing_ctrl.sv
// Directed bench for cl_timing_ctrl (TAPS=2): a table of whole-frame shapes
// plus hand sequences for stall, stop, mid-frame reset and zero blanking.
module tb_cl_timing_ctrl;

  localparam int unsigned TAPS = 2;
  localparam int unsigned CW   = 16;

  logic          pixel_clk = 1'b0;
  logic          sys_rst   = 1'b1;
  logic [CW-1:0] cfg_width = '0, cfg_height = '0, cfg_vblank = '0;
  logic [7:0]    cfg_hblank = '0;
  logic          cfg_cont = 1'b0, start = 1'b0, stop = 1'b0, pix_avail = 1'b1;
  logic          pix_rd, fval, lval, dval, busy, frame_done, cfg_err;
  logic [CW-1:0] line_cnt, beat_cnt;

  int checks = 0;
  int errors = 0;

  always #5 pixel_clk = ~pixel_clk;

  cl_timing_ctrl #(.TAPS(TAPS), .CW(CW)) dut (
    .pixel_clk  (pixel_clk),
    .sys_rst    (sys_rst),
    .cfg_width  (cfg_width),
    .cfg_height (cfg_height),
    .cfg_hblank (cfg_hblank),
    .cfg_vblank (cfg_vblank),
    .cfg_cont   (cfg_cont),
    .start      (start),
    .stop       (stop),
    .pix_avail  (pix_avail),
    .pix_rd     (pix_rd),
    .fval       (fval),
    .lval       (lval),
    .dval       (dval),
    .line_cnt   (line_cnt),
    .beat_cnt   (beat_cnt),
    .busy       (busy),
    .frame_done (frame_done),
    .cfg_err    (cfg_err)
  );

  typedef struct {
    int w; int h; int hb; int vb; bit cont; bit stop0;
    int e_err; int e_dval; int e_lpulse; int e_fval; int e_busy; int e_fd;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic set_cfg(input int w, input int h, input int hb, input int vb, input bit cont);
    cfg_width  = CW'(w);
    cfg_height = CW'(h);
    cfg_hblank = 8'(hb);
    cfg_vblank = CW'(vb);
    cfg_cont   = cont;
  endtask

  task automatic scramble_cfg();
    cfg_width  = 16'd3;
    cfg_height = 16'd9;
    cfg_hblank = 8'd200;
    cfg_vblank = 16'd300;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " fval"}, fval, 0);
    check({tag, " lval"}, lval, 0);
    check({tag, " dval"}, dval, 0);
    check({tag, " pix_rd"}, pix_rd, 0);
    check({tag, " busy"}, busy, 0);
    check({tag, " frame_done"}, frame_done, 0);
    check({tag, " cfg_err"}, cfg_err, 0);
    check({tag, " line_cnt"}, line_cnt, 0);
    check({tag, " beat_cnt"}, beat_cnt, 0);
  endtask

  task automatic wait_idle(input string tag, input int bound);
    bit ok;
    ok = 0;
    for (int n = 0; n < bound && !ok; n++) begin
      @(negedge pixel_clk); #1;
      if (!busy) ok = 1;
    end
    check({tag, " back to idle"}, ok, 1);
  endtask

  // Runs one frame sequence from a table record and compares aggregate shape.
  task automatic run_vec(input int idx, input vec_t t);
    int n_err, n_dval, n_rd, n_lp, n_fval, n_busy, n_fd;
    logic prev_l;
    bit done;
    string p;
    n_err = 0; n_dval = 0; n_rd = 0; n_lp = 0; n_fval = 0; n_busy = 0; n_fd = 0;
    prev_l = 1'b0; done = 0;
    p = $sformatf("vec%0d", idx);
    @(negedge pixel_clk);
    set_cfg(t.w, t.h, t.hb, t.vb, t.cont);
    stop  = t.stop0;
    start = 1'b1;
    for (int n = 1; n <= 500 && !done; n++) begin
      @(negedge pixel_clk);
      if (n == 1) begin
        start = 1'b0;
        stop  = 1'b0;
        scramble_cfg();
      end
      #1;
      n_err  += int'(cfg_err);
      n_dval += int'(dval);
      n_rd   += int'(pix_rd);
      n_fval += int'(fval);
      n_busy += int'(busy);
      n_fd   += int'(frame_done);
      if (lval && !prev_l) n_lp++;
      prev_l = lval;
      if (!busy) done = 1;
    end
    check({p, " finished"}, done, 1);
    check({p, " cfg_err pulses"}, n_err, t.e_err);
    check({p, " dval beats"}, n_dval, t.e_dval);
    check({p, " pix_rd beats"}, n_rd, t.e_dval);
    check({p, " lval pulses"}, n_lp, t.e_lpulse);
    check({p, " fval cycles"}, n_fval, t.e_fval);
    check({p, " busy cycles"}, n_busy, t.e_busy);
    check({p, " frame_done pulses"}, n_fd, t.e_fd);
  endtask

  task automatic run_stall();
    int rd0, stalls;
    bit reached;
    rd0 = 0; stalls = 0; reached = 0;
    @(negedge pixel_clk);
    set_cfg(8, 3, 2, 4, 0);
    pix_avail = 1'b1;
    start     = 1'b1;
    for (int n = 1; n <= 100 && !reached; n++) begin
      @(negedge pixel_clk);
      if (n == 1) start = 1'b0;
      pix_avail = !(rd0 == 2 && stalls < 3);
      #1;
      if (!pix_avail) begin
        check("stall lval", lval, 1);
        check("stall dval", dval, 0);
        check("stall pix_rd", pix_rd, 0);
        check("stall beat_cnt", beat_cnt, 2);
        stalls++;
      end
      if (pix_rd && line_cnt == 0) rd0++;
      if (line_cnt == 1) reached = 1;
    end
    pix_avail = 1'b1;
    check("stall reached line 1", reached, 1);
    check("stall cycle count", stalls, 3);
    check("stall line0 pix_rd count", rd0, 4);
    wait_idle("stall", 100);
  endtask

  task automatic run_stop();
    int fd, fvc, bc, idle_busy;
    bit stop_sent, done;
    fd = 0; fvc = 0; bc = 0; idle_busy = 0; stop_sent = 0; done = 0;
    @(negedge pixel_clk);
    set_cfg(8, 3, 2, 4, 1);
    start = 1'b1;
    for (int n = 1; n <= 400 && !done; n++) begin
      @(negedge pixel_clk);
      start = (n == 10);  // stray start mid-frame must be ignored
      stop  = 1'b0;
      if (fd == 1 && line_cnt == 1 && lval && !stop_sent) begin
        stop      = 1'b1;
        stop_sent = 1;
      end
      #1;
      fd  += int'(frame_done);
      fvc += int'(fval);
      bc  += int'(busy);
      if (!busy) done = 1;
    end
    start = 1'b0;
    stop  = 1'b0;
    check("stop finished", done, 1);
    check("stop was sent in frame 2", stop_sent, 1);
    check("stop frame_done pulses", fd, 2);
    check("stop fval cycles", fvc, 38);
    check("stop busy cycles", bc, 46);
    for (int n = 0; n < 10; n++) begin
      @(negedge pixel_clk); #1;
      idle_busy += int'(busy) + int'(fval);
    end
    check("stop stays idle", idle_busy, 0);
    cfg_cont = 1'b0;
  endtask

  task automatic run_reset_mid();
    bit found;
    int after;
    found = 0; after = 0;
    @(negedge pixel_clk);
    set_cfg(8, 3, 2, 4, 0);
    pix_avail = 1'b1;
    start     = 1'b1;
    for (int n = 1; n <= 50 && !found; n++) begin
      @(negedge pixel_clk);
      if (n == 1) start = 1'b0;
      #1;
      if (lval && beat_cnt == 1) found = 1;
    end
    check("reset reached ACTIVE", found, 1);
    #1 sys_rst = 1'b1;
    #1 check_zero("mid-frame reset");
    @(negedge pixel_clk);
    @(negedge pixel_clk);
    #1 sys_rst = 1'b0;
    for (int n = 0; n < 30; n++) begin
      @(negedge pixel_clk); #1;
      after += int'(busy) + int'(frame_done) + int'(fval);
    end
    check("after reset no activity", after, 0);
  endtask

  task automatic run_zero_blank();
    int e_f[9], e_l[9], e_b[9], e_d[9], e_ln[9];
    e_f  = '{1, 1, 1, 1, 1, 1, 1, 0, 0};
    e_l  = '{0, 1, 1, 0, 1, 1, 0, 0, 0};
    e_b  = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    e_d  = '{0, 0, 0, 0, 0, 0, 1, 0, 0};
    e_ln = '{0, 0, 0, 1, 1, 1, 1, 1, 1};
    @(negedge pixel_clk);
    set_cfg(4, 2, 0, 0, 0);
    start = 1'b1;
    for (int n = 0; n < 9; n++) begin
      @(negedge pixel_clk);
      start = 1'b0;
      #1;
      check($sformatf("zb c%0d fval", n + 1), fval, e_f[n]);
      check($sformatf("zb c%0d lval", n + 1), lval, e_l[n]);
      check($sformatf("zb c%0d busy", n + 1), busy, e_b[n]);
      check($sformatf("zb c%0d frame_done", n + 1), frame_done, e_d[n]);
      check($sformatf("zb c%0d line_cnt", n + 1), line_cnt, e_ln[n]);
    end
  endtask

  initial begin
    int idle_busy;
    //          w   h  hb vb cont stop0  err dval lp fval busy fd
    vecs[0] = '{8,  3, 2, 4, 0,   0,     0,  12,  3, 19,  23,  1};
    vecs[1] = '{7,  3, 2, 4, 0,   0,     1,  0,   0, 0,   0,   0};
    vecs[2] = '{0,  3, 2, 4, 0,   0,     1,  0,   0, 0,   0,   0};
    vecs[3] = '{8,  0, 2, 4, 0,   0,     1,  0,   0, 0,   0,   0};
    vecs[4] = '{2,  1, 0, 0, 0,   0,     0,  1,   1, 3,   4,   1};
    vecs[5] = '{6,  2, 5, 1, 0,   0,     0,  6,   2, 17,  18,  1};
    vecs[6] = '{16, 1, 1, 0, 0,   0,     0,  8,   1, 10,  11,  1};
    vecs[7] = '{4,  2, 1, 1, 1,   1,     0,  4,   2, 7,   8,   1};

    repeat (2) @(negedge pixel_clk);
    #1 check_zero("reset");
    @(negedge pixel_clk);
    #1 sys_rst = 1'b0;
    idle_busy = 0;
    for (int n = 0; n < 5; n++) begin
      @(negedge pixel_clk); #1;
      idle_busy += int'(busy);
    end
    check("idle after reset release", idle_busy, 0);

    for (int v = 0; v < 8; v++) run_vec(v, vecs[v]);
    run_stall();
    run_stop();
    run_zero_blank();
    run_reset_mid();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
